// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the external memory bus arbiter and its beat counter.
//   arb_state_t   : arbiter ownership state (IDLE, IBURST, DBURST)
//   requester_t   : identifies which cache last owned the bus
//   BEATS_DEFAULT : default number of words per cache-block burst
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IBURST,
        DBURST
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

    localparam int BEATS_DEFAULT = 4;

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Bundle of cache-side request signals and memory-bus signals for the arbiter.
//   master : arbiter view (takes requests and HReady, drives grants, strobes, bus)
//   slave  : cache/memory view (drives requests and HReady, observes the rest)
interface memory_bus_arbiter_if #(
    parameter int BEATS      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                       IReq;
    logic [ADDR_WIDTH-1:0]      IAddr;
    logic                       DReq;
    logic                       DWrite;
    logic [ADDR_WIDTH-1:0]      DAddr;
    logic [DATA_WIDTH-1:0]      DWData;
    logic                       IGrant;
    logic                       DGrant;
    logic                       IBusReady;
    logic                       DBusReady;
    logic [$clog2(BEATS)-1:0]   Counter;
    logic                       HRequest;
    logic                       HWrite;
    logic [ADDR_WIDTH-1:0]      HAddr;
    logic [DATA_WIDTH-1:0]      HWData;
    logic                       HReady;

    modport master (
        input  IReq, IAddr, DReq, DWrite, DAddr, DWData, HReady,
        output IGrant, DGrant, IBusReady, DBusReady, Counter,
               HRequest, HWrite, HAddr, HWData
    );

    modport slave (
        output IReq, IAddr, DReq, DWrite, DAddr, DWData, HReady,
        input  IGrant, DGrant, IBusReady, DBusReady, Counter,
               HRequest, HWrite, HAddr, HWData
    );

endinterface

// File: rtl/memory_bus_arbiter_beat_counter.sv
// Beat index counter for one cache-block burst; shared with the cache controllers.
//   clk   : clock
//   clear : synchronous clear to beat 0
//   en    : a beat completed this cycle, advance (wraps BEATS-1 -> 0)
//   count : current beat index
//   last  : current beat is the final beat of the block
module beat_counter
    import mem_bus_pkg::*;
#(
    parameter int BEATS = BEATS_DEFAULT,
    localparam int CW   = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    // BEATS is a power of two, so the natural wrap of the counter returns it to 0
    // after the final beat without any extra compare.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CW'(BEATS - 1));

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates the single external memory bus between the I-cache and D-cache
// controllers. A granted requester owns the bus for one full block burst; the
// arbiter produces the beat address, write data gating, per-requester BusReady
// strobes and the shared beat counter. A D writeback is locked together with
// the D refill that follows it.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master modport (requests in, grants/strobes/bus signals out)
module memory_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int BEATS      = BEATS_DEFAULT,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    memory_bus_arbiter_if.master bus
);

    localparam int CW   = $clog2(BEATS);
    localparam int OFFS = CW + 2;
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = {{(ADDR_WIDTH-OFFS){1'b1}}, {OFFS{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] NO_DATA    = '0;

    arb_state_t            state;
    arb_state_t            state_nxt;
    requester_t            last_grant;
    logic                  lock;
    logic                  writeq;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CW-1:0]         counter;
    logic                  last_beat;
    logic                  in_burst;
    logic                  beat_done;
    logic                  burst_end;

    assign in_burst  = (state != IDLE);
    assign beat_done = in_burst && bus.HReady;
    assign burst_end = beat_done && last_beat;

    beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk   (clk),
        .clear (reset),
        .en    (beat_done),
        .count (counter),
        .last  (last_beat)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // The lock wins over round-robin so a writeback is always
                // followed by its refill before the I-cache can cut in.
                if (lock && bus.DReq) begin
                    state_nxt = DBURST;
                end else if (bus.IReq && bus.DReq) begin
                    state_nxt = (last_grant == REQ_I) ? DBURST : IBURST;
                end else if (bus.IReq) begin
                    state_nxt = IBURST;
                end else if (bus.DReq) begin
                    state_nxt = DBURST;
                end
            end
            IBURST, DBURST: begin
                if (burst_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= REQ_I;
            lock       <= 1'b0;
            writeq     <= 1'b0;
            base_addr  <= '0;
        end else begin
            state <= state_nxt;

            // The lock lives only for the single IDLE cycle after a writeback.
            if (state == IDLE) begin
                lock <= 1'b0;
            end else if (state == DBURST && writeq && burst_end) begin
                lock <= 1'b1;
            end

            if (state == IDLE && state_nxt == IBURST) begin
                base_addr  <= bus.IAddr & BLOCK_MASK;
                writeq     <= 1'b0;
                last_grant <= REQ_I;
            end else if (state == IDLE && state_nxt == DBURST) begin
                base_addr  <= bus.DAddr & BLOCK_MASK;
                writeq     <= bus.DWrite;
                last_grant <= REQ_D;
            end
        end
    end

    assign bus.IGrant    = (state == IBURST);
    assign bus.DGrant    = (state == DBURST);
    assign bus.IBusReady = (state == IBURST) && bus.HReady;
    assign bus.DBusReady = (state == DBURST) && bus.HReady;
    assign bus.Counter   = counter;
    assign bus.HRequest  = in_burst;
    assign bus.HWrite    = in_burst && writeq;
    assign bus.HAddr     = in_burst ? (base_addr | {{(ADDR_WIDTH-OFFS){1'b0}}, counter, 2'b00})
                                    : '0;
    assign bus.HWData    = (in_burst && writeq) ? bus.DWData : NO_DATA;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed scenarios followed by
// randomized request/address/wait-state traffic, all predicted by a
// transaction-level model (who wins each IDLE decision, block base address,
// and per-beat address = base + 4*beat).
module tb_memory_bus_arbiter;

    localparam int BEATS = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BLK   = BEATS * 4;

    localparam int NONE  = 0;
    localparam int WHO_I = 1;
    localparam int WHO_D = 2;

    logic clk;
    logic reset;

    memory_bus_arbiter_if #(.BEATS(BEATS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_bus_arbiter #(
        .BEATS      (BEATS),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            last_who = WHO_I;
    bit            prev_wb  = 1'b0;
    logic [AW-1:0] cur_base = '0;
    bit            cur_wr   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input bit ir, input bit dr, input bit lk, input int last);
        if (lk && dr)   return WHO_D;
        if (ir && dr)   return (last == WHO_I) ? WHO_D : WHO_I;
        if (ir)         return WHO_I;
        if (dr)         return WHO_D;
        return NONE;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_igrant"},  bus.IGrant,    0);
        chk({tag, "_dgrant"},  bus.DGrant,    0);
        chk({tag, "_ibr"},     bus.IBusReady, 0);
        chk({tag, "_dbr"},     bus.DBusReady, 0);
        chk({tag, "_counter"}, bus.Counter,   0);
        chk({tag, "_hreq"},    bus.HRequest,  0);
        chk({tag, "_hwrite"},  bus.HWrite,    0);
        chk({tag, "_haddr"},   bus.HAddr,     0);
        chk({tag, "_hwdata"},  bus.HWData,    0);
    endtask

    // One IDLE cycle: present requests, confirm the bus is quiet, predict the winner.
    task automatic idle_step(input bit ir, input bit dr, input bit dw,
                             input logic [AW-1:0] ia, input logic [AW-1:0] da,
                             output int who);
        logic [AW-1:0] a;
        @(negedge clk);
        reset      = 1'b0;
        bus.IReq   = ir;
        bus.DReq   = dr;
        bus.DWrite = dw;
        bus.IAddr  = ia;
        bus.DAddr  = da;
        bus.HReady = 1'($urandom_range(0, 1));
        bus.DWData = $urandom;
        #1;
        check_idle("idle");
        who     = pick(ir, dr, prev_wb, last_who);
        prev_wb = 1'b0;
        if (who != NONE) begin
            last_who = who;
            a        = (who == WHO_I) ? ia : da;
            cur_base = a - (a % BLK);
            cur_wr   = (who == WHO_D) && dw;
        end
    endtask

    // Run one burst owned by 'who'. wmask: one wait cycle before each marked beat;
    // rnd: extra random waits and input noise; drop_after: owner drops its request
    // after that beat; reset_at: assert reset on that beat and abandon the burst.
    task automatic do_burst(input int who, input logic [BEATS-1:0] wmask, input bit rnd,
                            input int drop_after, input int reset_at, output int ncyc);
        int  beat    = 0;
        bit  waited  = 1'b0;
        bit  aborted = 1'b0;
        bit  hr;
        ncyc = 0;
        while (beat < BEATS && !aborted && ncyc < 64) begin
            @(negedge clk);
            hr = 1'b1;
            if (wmask[beat] && !waited) hr = 1'b0;
            else if (rnd && $urandom_range(0, 3) == 0) hr = 1'b0;
            if (drop_after >= 0 && beat > drop_after) begin
                if (who == WHO_I) bus.IReq = 1'b0;
                else              bus.DReq = 1'b0;
            end
            if (beat == reset_at) begin
                reset   = 1'b1;
                hr      = 1'b1;
                aborted = 1'b1;
            end
            bus.HReady = hr;
            bus.DWData = $urandom;
            if (rnd) begin
                bus.IAddr  = $urandom;
                bus.DAddr  = $urandom;
                bus.DWrite = 1'($urandom_range(0, 1));
            end
            #1;
            chk("igrant",  bus.IGrant,    who == WHO_I);
            chk("dgrant",  bus.DGrant,    who == WHO_D);
            chk("counter", bus.Counter,   beat);
            chk("hreq",    bus.HRequest,  1);
            chk("hwrite",  bus.HWrite,    cur_wr);
            chk("haddr",   bus.HAddr,     cur_base + 4 * beat);
            chk("hwdata",  bus.HWData,    cur_wr ? bus.DWData : 0);
            chk("ibr",     bus.IBusReady, (who == WHO_I) && hr);
            chk("dbr",     bus.DBusReady, (who == WHO_D) && hr);
            if (hr) begin
                beat++;
                waited = 1'b0;
            end else begin
                waited = 1'b1;
            end
            ncyc++;
        end
        if (aborted) begin
            last_who = WHO_I;
            prev_wb  = 1'b0;
        end else begin
            if (beat < BEATS) chk("burst_timeout", beat, BEATS);
            prev_wb = (who == WHO_D) && cur_wr;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int n;

        reset      = 1'b1;
        bus.IReq   = 1'b0;
        bus.DReq   = 1'b0;
        bus.DWrite = 1'b0;
        bus.IAddr  = '0;
        bus.DAddr  = '0;
        bus.DWData = '0;
        bus.HReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_idle("reset");

        // I only, HAddr 0x1230..0x123C
        idle_step(1, 0, 0, 32'h0000_1234, 32'h0, who);
        chk("ionly_pick", who, WHO_I);
        chk("ionly_base", cur_base, 32'h0000_1230);
        do_burst(who, '0, 0, -1, -1, n);
        chk("ionly_len", n, BEATS);
        idle_step(0, 0, 0, 32'h0, 32'h0, who);

        // Ties: D first after reset, then I, then D again
        idle_step(1, 1, 0, 32'h0000_5004, 32'h0000_6008, who);
        chk("tie1_pick", who, WHO_D);
        do_burst(who, '0, 0, -1, -1, n);
        idle_step(1, 1, 0, 32'h0000_5004, 32'h0000_6008, who);
        chk("tie2_pick", who, WHO_I);
        do_burst(who, '0, 0, -1, -1, n);
        idle_step(1, 1, 0, 32'h0000_5004, 32'h0000_6008, who);
        chk("tie3_pick", who, WHO_D);
        do_burst(who, '0, 0, -1, -1, n);

        // Writeback lock: refill at 0x2000 beats a pending I request
        idle_step(1, 0, 0, 32'h0000_7000, 32'h0, who);
        do_burst(who, '0, 0, -1, -1, n);
        idle_step(1, 1, 1, 32'h0000_7000, 32'h0000_2000, who);
        chk("wb_pick", who, WHO_D);
        chk("wb_write", cur_wr, 1);
        do_burst(who, '0, 0, -1, -1, n);
        idle_step(1, 1, 0, 32'h0000_7000, 32'h0000_2000, who);
        chk("refill_pick", who, WHO_D);
        chk("refill_base", cur_base, 32'h0000_2000);
        do_burst(who, '0, 0, -1, -1, n);
        idle_step(1, 0, 0, 32'h0000_7000, 32'h0, who);
        chk("after_refill_pick", who, WHO_I);
        do_burst(who, '0, 0, -1, -1, n);

        // Wait states on beats 1 and 3
        idle_step(1, 0, 0, 32'h0000_ABCC, 32'h0, who);
        do_burst(who, 4'b1010, 0, -1, -1, n);
        chk("wait_len", n, 6);

        // Request drop mid-burst, then nothing granted
        idle_step(1, 0, 0, 32'h0000_3310, 32'h0, who);
        do_burst(who, '0, 0, 1, -1, n);
        chk("drop_len", n, BEATS);
        idle_step(0, 0, 0, 32'h0, 32'h0, who);
        idle_step(0, 0, 0, 32'h0, 32'h0, who);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            idle_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, who);
            if (who != NONE) do_burst(who, '0, 1, -1, -1, n);
        end

        // Reset on beat 2 of a D writeback, then a tie goes to D
        idle_step(0, 0, 0, 32'h0, 32'h0, who);
        idle_step(0, 1, 1, 32'h0, 32'h0000_4440, who);
        chk("rst_wb_pick", who, WHO_D);
        do_burst(who, '0, 0, -1, 2, n);
        idle_step(1, 1, 0, 32'h0000_9000, 32'h0000_8000, who);
        chk("rst_tie_pick", who, WHO_D);
        do_burst(who, '0, 0, -1, -1, n);
        idle_step(0, 0, 0, 32'h0, 32'h0, who);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Shares the single external memory bus between the instruction cache controller and the writeback data cache controller. Each granted requester owns the bus for one full cache-block burst of BEATS words. The arbiter generates the bus address for each beat and returns a per-requester BusReady strobe and a shared beat counter. A data-cache writeback is kept atomic with the refill that follows it.

## Interface
Parameters:
- BEATS, 4, words per cache block burst; power of two, ≥2
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- IReq  in  1  I-cache block-read request
- IAddr  in  ADDR_WIDTH  I-cache miss address (any byte in the block)
- DReq  in  1  D-cache request
- DWrite  in  1  1 = writeback burst, 0 = refill burst
- DAddr  in  ADDR_WIDTH  D-cache block address
- DWData  in  DATA_WIDTH  D-cache write word for the current beat
- IGrant  out  1  I-cache owns the bus
- DGrant  out  1  D-cache owns the bus
- IBusReady  out  1  beat complete for the I-cache
- DBusReady  out  1  beat complete for the D-cache
- Counter  out  log2(BEATS)  index of the current beat
- HRequest  out  1  bus transfer active
- HWrite  out  1  bus write
- HAddr  out  ADDR_WIDTH  word address of the current beat
- HWData  out  DATA_WIDTH  bus write data
- HReady  in  1  memory completed the current beat

## Operation
- States: IDLE, IBURST, DBURST. Reset puts the block in IDLE.
- In IDLE, requests are sampled and a grant is decided for the next cycle:
  - If Lock=1 and DReq=1: DBURST.
  - Else if only one request is high: that requester's burst.
  - Else if both are high: round-robin. The requester opposite to LastGrant wins. After reset LastGrant = I, so D wins the first tie.
  - Else: remain in IDLE.
- At grant, the following are registered: BaseAddr (IAddr or DAddr with its low log2(BEATS)+2 bits cleared), WriteQ (DWrite for a D grant, 0 for an I grant), and LastGrant.
- Lock register:
  - Set when a D burst with WriteQ=1 completes.
  - Cleared on any IDLE cycle and on reset.
  - Effect: a writeback is always followed by the D refill before any I burst.
- During a burst:
  - HRequest = 1, HWrite = WriteQ.
  - HAddr = BaseAddr | (Counter << 2).
  - HWData = DWData when WriteQ = 1, else 0.
- A beat completes on any burst cycle with HReady = 1:
  - The owner's BusReady equals HReady in that cycle.
  - Counter increments, wrapping from BEATS-1 to 0.
- On the beat with Counter = BEATS-1 and HReady = 1: next state is IDLE and Counter returns to 0.
- Requests dropping mid-burst are ignored. A burst cannot be aborted except by reset. Requesters hold Req until their final beat.
- Read data is not routed through this block. HRData fans out directly to both caches, qualified by the per-requester BusReady.

## Timing
- Reset values: state IDLE, Counter 0, LastGrant I, Lock 0, WriteQ 0, BaseAddr 0.
- All outputs are 0 at reset: IGrant, DGrant, IBusReady, DBusReady, HRequest, HWrite, HAddr, HWData.
- Grant latency: a request high in IDLE at edge n produces the grant and HRequest in cycle n+1.
- Back-to-back bursts are separated by exactly one IDLE cycle.
- Best-case burst length is BEATS cycles. Each HReady=0 cycle adds one wait cycle, and all outputs are held during it.
- IGrant/DGrant are registered state decodes. BusReady, HAddr and HWData are combinational from state, Counter and HReady.
- A request arriving during another burst is serviced after that burst ends, via the IDLE cycle.
- Reset asserted mid-burst: IDLE on the next edge and all registers return to reset values. The bus cycle in flight is abandoned.

## Structure
- Shared package mem_bus_pkg:
  - arb_state_t enum {IDLE, IBURST, DBURST}
  - requester_t enum {REQ_I, REQ_D}
  - BEATS constant default
- Sub-module beat_counter:
  - log2(BEATS)-bit counter with en (beat done), clear, and last-beat flag output.
  - Reused later by the caches in place of their own counters.

## Test plan
- **I only:** IReq=1, IAddr=0x0000_1234, HReady tied 1.
  - IGrant rises one cycle later; HAddr = 0x1230, 0x1234, 0x1238, 0x123C.
  - IBusReady high for 4 cycles, then IDLE.
- **Tie after reset:** IReq=DReq=1 with DWrite=0.
  - D granted first, then one IDLE cycle, then I granted.
  - A second tie after both bursts grants D again, since LastGrant=I.
- **Writeback lock:** DReq=1, DWrite=1, DAddr=0x2000 and IReq=1 held.
  - Write burst: HWrite=1, HWData follows DWData per beat.
  - DWrite=0 after the last beat, then a D refill at 0x2000 before any I grant.
- **Wait states:** HReady=0 on beats 1 and 3 of an I burst.
  - Burst takes 6 cycles; Counter and HAddr are held while HReady=0; IBusReady asserts only on HReady=1 cycles.
- **Reset mid-burst:** reset asserted on beat 2 of a D write.
  - Next cycle all outputs 0, Counter 0, Lock 0; a subsequent tie grants D.
- **Request drop mid-burst:** IReq drops after beat 1.
  - Burst still completes all 4 beats; no grant afterwards while both requests are low.
